// File: rtl/batrider_rom_packer_if.sv
// batrider_rom_packer_if: loader byte stream in, SDRAM programming bus out.
interface batrider_rom_packer_if;
    logic        downloading;
    logic [25:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rdy;
    logic        dwnld_busy;
    logic        overflow;

    modport master (
        output downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_rdy,
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, dwnld_busy, overflow
    );
    modport slave (
        input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_rdy,
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we, dwnld_busy, overflow
    );
endinterface

// File: rtl/batrider_rom_packer.sv
// batrider_rom_packer: packs loader bytes into 16-bit SDRAM writes through a 4-deep FIFO.
module batrider_rom_packer (
    input  logic clk,
    input  logic rst,
    batrider_rom_packer_if.slave bus
);
    localparam logic [25:0] PCM_START = 26'h140000;
    localparam logic [25:0] GFX_START = 26'h340000;
    localparam logic [25:0] GFX_SPLIT = 26'h740000;
    localparam logic [25:0] ROM_END   = 26'hB40000;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } entry_t;
    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [7:0]  data;
    } pend_t;

    state_t      state, state_n;
    entry_t      mem [4];
    entry_t      enq_e;
    pend_t       pend, pend_n;
    logic        pend_v, pend_v_n, dl_q, fall, in_range, enq, deq, push;
    logic [1:0]  bank, wp, rp;
    logic [2:0]  count;
    logic [25:0] base;
    logic [21:0] waddr;

    always_comb begin
        in_range = bus.ioctl_addr < ROM_END;
        bank = bus.ioctl_addr < PCM_START ? 2'd0 :
               bus.ioctl_addr < GFX_START ? 2'd1 :
               bus.ioctl_addr < GFX_SPLIT ? 2'd2 : 2'd3;
        base = bank == 2'd0 ? 26'd0 : bank == 2'd1 ? PCM_START :
               bank == 2'd2 ? GFX_START : GFX_SPLIT;
        waddr = 22'((bus.ioctl_addr - base) >> 1);
        fall = dl_q & ~bus.downloading;
        enq = 1'b0;
        enq_e = '{pend.ba, pend.addr, {8'h00, pend.data}, 2'b10};
        pend_v_n = pend_v;
        pend_n = pend;
        // The download-end flush wins over a coincident strobe, which is dropped
        if (fall) begin
            enq = pend_v;
            pend_v_n = 1'b0;
        end else if (bus.ioctl_wr && in_range) begin
            if (!bus.ioctl_addr[0]) begin
                enq = pend_v;
                pend_v_n = 1'b1;
                pend_n = '{bank, waddr, bus.ioctl_dout};
            end else begin
                enq = 1'b1;
                pend_v_n = 1'b0;
                enq_e = (pend_v && pend.ba == bank && pend.addr == waddr) ?
                        '{bank, waddr, {bus.ioctl_dout, pend.data}, 2'b00} :
                        '{bank, waddr, {bus.ioctl_dout, 8'h00}, 2'b01};
            end
        end
    end

    assign deq  = state == IDLE && count != 3'd0;
    assign push = enq && (count != 3'd4 || deq);

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (deq ? WAIT : IDLE) : (bus.prog_rdy ? IDLE : WAIT);
        bus.prog_we = state == WAIT;
        bus.dwnld_busy = bus.downloading | pend_v | (count != 3'd0) | (state == WAIT);
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= enq_e;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q <= 1'b0;
            pend_v <= 1'b0;
            pend <= '0;
            wp <= '0;
            rp <= '0;
            count <= '0;
            bus.overflow <= 1'b0;
            {bus.prog_ba, bus.prog_addr, bus.prog_data, bus.prog_mask} <= '0;
        end else begin
            dl_q <= bus.downloading;
            pend_v <= pend_v_n;
            pend <= pend_n;
            wp <= wp + 2'(push);
            rp <= rp + 2'(deq);
            count <= count + 3'(push) - 3'(deq);
            bus.overflow <= bus.overflow | (enq & ~push);
            if (deq) {bus.prog_ba, bus.prog_addr, bus.prog_data, bus.prog_mask} <= mem[rp];
        end
    end
endmodule
